// File: rtl/int_ctrl_if.sv
// CPU-side register bus of the interrupt controller (Bridge PrAddr/PrWD/PrWE/PrRD).
// The master drives address, data and byte enables. The slave returns combinational read data.
interface int_ctrl_if;
   logic [31:0] addr;
   logic [31:0] wd;
   logic [3:0]  we;
   logic [31:0] rd;

   modport master (output addr, output wd, output we, input rd);
   modport slave  (input addr, input wd, input we, output rd);
endinterface

// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: latches up to six lines (level or edge), masks them,
// and presents HWInt plus the lowest pending line index to CP0.
module int_ctrl #(
   parameter int          N_SRC     = 6,
   parameter logic [31:0] BASE_ADDR = 32'h0000_7F20
) (
   input  logic         clk,
   input  logic         reset,
   int_ctrl_if.slave    bus,
   input  logic [5:0]   irq_in,
   input  logic         int_ack,
   input  logic [2:0]   ack_id,
   output logic [5:0]   hwint,
   output logic         irq_req,
   output logic [2:0]   irq_id
);

   // Lines at or above N_SRC are tied off in every register.
   localparam logic [5:0] VALID = 6'((7'd1 << N_SRC) - 7'd1);

   logic [5:0] prev, pending, mask, mode;
   logic [5:0] pending_nxt, rise, ack_vec, set_vec, clr_vec;
   logic       hit, wr;
   logic       pend_wr, mask_wr, mode_wr, swset_wr;
   logic [5:0] rd_reg;

   assign hit      = (bus.addr[31:4] == BASE_ADDR[31:4]);
   assign wr       = hit && (bus.we != 4'd0);
   assign pend_wr  = wr && (bus.addr[3:2] == 2'd0);
   assign mask_wr  = wr && (bus.addr[3:2] == 2'd1);
   assign mode_wr  = wr && (bus.addr[3:2] == 2'd2);
   assign swset_wr = wr && (bus.addr[3:2] == 2'd3);

   wire unused_bus = &{1'b0, bus.wd[31:6], bus.addr[1:0]};

   // Ack handshake: int_ack is a single-cycle pulse qualifying ack_id; the controller
   // always accepts it (no ready), and ids with no matching line are simply ignored.
   always_comb begin
      ack_vec = 6'd0;
      for (int i = 0; i < 6; i++) begin
         ack_vec[i] = int_ack && (ack_id == 3'(i));
      end
   end

   assign rise    = irq_in & ~prev;
   assign set_vec = rise | (swset_wr ? bus.wd[5:0] : 6'd0);
   assign clr_vec = (pend_wr ? bus.wd[5:0] : 6'd0) | ack_vec;

   // Set beats clear so an edge arriving with its own ack is not lost.
   // Level bits follow the line directly, using the mode held before any same-cycle write.
   assign pending_nxt = ((mode & (set_vec | (pending & ~clr_vec))) | (~mode & irq_in)) & VALID;

   always_ff @(posedge clk) begin
      if (reset) begin
         prev    <= 6'd0;
         pending <= 6'd0;
         mask    <= 6'd0;
         mode    <= 6'd0;
      end else begin
         prev    <= irq_in;
         pending <= pending_nxt;
         if (mask_wr) mask <= bus.wd[5:0] & VALID;
         if (mode_wr) mode <= bus.wd[5:0] & VALID;
      end
   end

   always_comb begin
      rd_reg = 6'd0;
      case (bus.addr[3:2])
         2'd0:    rd_reg = pending;
         2'd1:    rd_reg = mask;
         2'd2:    rd_reg = mode;
         default: rd_reg = 6'd0;
      endcase
   end

   assign bus.rd = hit ? {26'd0, rd_reg} : 32'd0;

   assign hwint   = pending & mask;
   assign irq_req = |hwint;

   // Scan downwards so the lowest set index wins.
   always_comb begin
      irq_id = 3'd7;
      for (int i = 5; i >= 0; i--) begin
         if (hwint[i]) irq_id = 3'(i);
      end
   end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: a per-line behavioural model checked every cycle,
// plus hand-computed literal expectations along the scripted scenarios.
module tb_int_ctrl;

  localparam int N_SRC = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  irq_in;
  logic        int_ack;
  logic [2:0]  ack_id;
  logic [5:0]  hwint;
  logic        irq_req;
  logic [2:0]  irq_id;

  int_ctrl_if bus_if ();

  int_ctrl #(.N_SRC(N_SRC), .BASE_ADDR(32'h0000_7F20)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if),
    .irq_in  (irq_in),
    .int_ack (int_ack),
    .ack_id  (ack_id),
    .hwint   (hwint),
    .irq_req (irq_req),
    .irq_id  (irq_id)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: one bit per line, updated from the rules at each rising edge
  bit m_pend [6];
  bit m_mask [6];
  bit m_mode [6];
  bit m_prev [6];

  always @(posedge clk) begin
    bit hit_w, wr_p, wr_m, wr_md, wr_s, s, c;
    bit np [6];
    hit_w = (bus_if.addr[31:4] == 28'h00007F2) && (bus_if.we != 4'd0);
    wr_p  = hit_w && bus_if.addr[3:2] == 2'd0;
    wr_m  = hit_w && bus_if.addr[3:2] == 2'd1;
    wr_md = hit_w && bus_if.addr[3:2] == 2'd2;
    wr_s  = hit_w && bus_if.addr[3:2] == 2'd3;
    for (int i = 0; i < 6; i++) begin
      if (reset || i >= N_SRC) begin
        np[i] = 1'b0;
      end else if (!m_mode[i]) begin
        np[i] = irq_in[i];
      end else begin
        s = (irq_in[i] && !m_prev[i]) || (wr_s && bus_if.wd[i]);
        c = (wr_p && bus_if.wd[i]) || (int_ack && int'(ack_id) == i);
        if (s)      np[i] = 1'b1;
        else if (c) np[i] = 1'b0;
        else        np[i] = m_pend[i];
      end
    end
    for (int i = 0; i < 6; i++) begin
      m_pend[i] = np[i];
      if (reset || i >= N_SRC) begin
        m_mask[i] = 1'b0;
        m_mode[i] = 1'b0;
        m_prev[i] = 1'b0;
      end else begin
        if (wr_m)  m_mask[i] = bus_if.wd[i];
        if (wr_md) m_mode[i] = bus_if.wd[i];
        m_prev[i] = irq_in[i];
      end
    end
  end

  // compare process: outputs are meaningful on every cycle once reset has been applied
  always @(negedge clk) begin
    logic [5:0]  e_hw, e_p, e_m, e_md;
    logic [2:0]  e_id;
    logic [31:0] e_rd;
    if (cmp_en) begin
      for (int i = 0; i < 6; i++) begin
        e_p[i]  = m_pend[i];
        e_m[i]  = m_mask[i];
        e_md[i] = m_mode[i];
        e_hw[i] = m_pend[i] && m_mask[i];
      end
      e_id = 3'd7;
      for (int i = 0; i < 6; i++) begin
        if (e_hw[i] && e_id == 3'd7) e_id = 3'(i);
      end
      e_rd = 32'd0;
      if (bus_if.addr[31:4] == 28'h00007F2) begin
        case (bus_if.addr[3:2])
          2'd0:    e_rd = {26'd0, e_p};
          2'd1:    e_rd = {26'd0, e_m};
          2'd2:    e_rd = {26'd0, e_md};
          default: e_rd = 32'd0;
        endcase
      end
      check("cyc_hwint", {26'd0, hwint}, {26'd0, e_hw});
      check("cyc_irq_req", {31'd0, irq_req}, {31'd0, (e_hw != 6'd0)});
      check("cyc_irq_id", {29'd0, irq_id}, {29'd0, e_id});
      check("cyc_rd", bus_if.rd, e_rd);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_if.addr = a;
    bus_if.wd   = d;
    bus_if.we   = 4'hF;
    tick();
    bus_if.we   = 4'h0;
    bus_if.addr = 32'd0;
  endtask

  task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus_if.addr = a;
    #1;
    check(name, bus_if.rd, exp);
    bus_if.addr = 32'd0;
  endtask

  initial begin
    reset = 1'b1;
    irq_in = 6'd0;
    int_ack = 1'b0;
    ack_id = 3'd0;
    bus_if.addr = 32'd0;
    bus_if.wd = 32'd0;
    bus_if.we = 4'd0;
    tick();
    cmp_en = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // reset state
    read_chk("rst_pending", 32'h7F20, 32'd0);
    read_chk("rst_mask",    32'h7F24, 32'd0);
    read_chk("rst_mode",    32'h7F28, 32'd0);
    read_chk("rst_swset",   32'h7F2C, 32'd0);
    check("rst_hwint", {26'd0, hwint}, 32'd0);
    check("rst_irq_id", {29'd0, irq_id}, 32'd7);

    // Timer0 level: high for three sampled cycles, visible one cycle late
    bus_write(32'h7F24, 32'h3);
    bus_write(32'h7F28, 32'h0);
    irq_in = 6'h01;
    check("lvl_lag", {26'd0, hwint}, 32'h0);
    tick();
    check("lvl_on1", {26'd0, hwint}, 32'h1);
    tick();
    tick();
    check("lvl_on3", {26'd0, hwint}, 32'h1);
    check("lvl_id", {29'd0, irq_id}, 32'd0);
    irq_in = 6'h00;
    tick();
    check("lvl_off", {26'd0, hwint}, 32'h0);

    // edge latch and priority
    bus_write(32'h7F28, 32'h7);
    bus_write(32'h7F24, 32'h7);
    irq_in = 6'h02;
    tick();
    irq_in = 6'h00;
    tick();
    tick();
    read_chk("edge_held", 32'h7F20, 32'h2);
    check("edge_id1", {29'd0, irq_id}, 32'd1);
    irq_in = 6'h01;
    tick();
    irq_in = 6'h00;
    tick();
    check("prio_id0", {29'd0, irq_id}, 32'd0);
    read_chk("prio_pend", 32'h7F20, 32'h3);
    bus_write(32'h7F20, 32'h1);
    check("w1c_id1", {29'd0, irq_id}, 32'd1);
    read_chk("w1c_pend", 32'h7F20, 32'h2);

    // ack versus new edge
    irq_in = 6'h04;
    tick();
    irq_in = 6'h00;
    tick();
    read_chk("b2_pend", 32'h7F20, 32'h6);
    irq_in = 6'h04;
    int_ack = 1'b1;
    ack_id = 3'd2;
    tick();
    int_ack = 1'b0;
    read_chk("ack_vs_edge", 32'h7F20, 32'h6);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    read_chk("ack_clr", 32'h7F20, 32'h2);
    tick();
    read_chk("held_no_reset", 32'h7F20, 32'h2);
    irq_in = 6'h00;
    int_ack = 1'b1;
    ack_id = 3'd6;
    tick();
    int_ack = 1'b0;
    read_chk("ack_oor", 32'h7F20, 32'h2);
    int_ack = 1'b1;
    ack_id = 3'd1;
    tick();
    int_ack = 1'b0;
    read_chk("ack_b1", 32'h7F20, 32'h0);

    // software set and mask
    bus_write(32'h7F28, 32'hF);
    bus_write(32'h7F24, 32'h7);
    bus_write(32'h7F2C, 32'h8);
    read_chk("swset_pend", 32'h7F20, 32'h8);
    check("swset_masked", {26'd0, hwint}, 32'h0);
    check("swset_id7", {29'd0, irq_id}, 32'd7);
    read_chk("swset_reads0", 32'h7F2C, 32'h0);
    bus_write(32'h7F24, 32'h8);
    check("unmask_hwint", {26'd0, hwint}, 32'h8);
    check("unmask_id3", {29'd0, irq_id}, 32'd3);
    bus_write(32'h7F2C, 32'h10);
    read_chk("swset_level", 32'h7F20, 32'h8);
    bus_write(32'h7F24, 32'hFFFF_FFFF);
    read_chk("mask_upper", 32'h7F24, 32'h3F);

    // decode: 0x7F30 is outside the window
    bus_write(32'h7F30, 32'h0);
    bus_write(32'h7F30, 32'hFFFF_FFFF);
    read_chk("miss_rd", 32'h7F30, 32'h0);
    read_chk("miss_mask", 32'h7F24, 32'h3F);
    read_chk("miss_mode", 32'h7F28, 32'hF);
    read_chk("miss_pend", 32'h7F20, 32'h8);

    // reset mid-operation beats a write, an ack and a rising edge
    bus_write(32'h7F2C, 32'h7);
    read_chk("pre_rst_pend", 32'h7F20, 32'hF);
    reset = 1'b1;
    irq_in = 6'h01;
    int_ack = 1'b1;
    ack_id = 3'd2;
    bus_if.addr = 32'h7F24;
    bus_if.wd = 32'h3F;
    bus_if.we = 4'hF;
    tick();
    reset = 1'b0;
    irq_in = 6'h00;
    int_ack = 1'b0;
    bus_if.we = 4'h0;
    bus_if.addr = 32'd0;
    read_chk("mid_rst_pend", 32'h7F20, 32'h0);
    read_chk("mid_rst_mask", 32'h7F24, 32'h0);
    check("mid_rst_hwint", {26'd0, hwint}, 32'h0);
    check("mid_rst_id", {29'd0, irq_id}, 32'd7);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
